// File: rtl/reg_bank_file_if.sv
// reg_bank_file_if: port bundle between the register control block and the banked pair file
interface reg_bank_file_if #(
    parameter int DW   = 8,
    parameter int SELW = 3,
    parameter int BW   = 1
);
    logic [SELW-1:0] rd_a_sel;
    logic [2*DW-1:0] rd_a_data;
    logic [SELW-1:0] rd_b_sel;
    logic [2*DW-1:0] rd_b_data;
    logic [SELW-1:0] wr_sel;
    logic [1:0]      wr_we;
    logic [2*DW-1:0] wr_data;
    logic            ex_af;
    logic            exx;
    logic            ex_de_hl;
    logic            inc_en;
    logic            inc_dec;
    logic [SELW-1:0] inc_sel;
    logic [BW-1:0]   bank_af;
    logic [BW-1:0]   bank_gp;

    modport master (
        output rd_a_sel, rd_b_sel, wr_sel, wr_we, wr_data, ex_af, exx, ex_de_hl, inc_en, inc_dec, inc_sel,
        input  rd_a_data, rd_b_data, bank_af, bank_gp
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, wr_sel, wr_we, wr_data, ex_af, exx, ex_de_hl, inc_en, inc_dec, inc_sel,
        output rd_a_data, rd_b_data, bank_af, bank_gp
    );
endinterface

// File: rtl/reg_bank_file.sv
// reg_bank_file: banked CPU register-pair file; inc/dec unit enabled by REG_BANK_FILE_INCDEC_EN
module reg_bank_file #(
    parameter int              DW      = 8,
    parameter int              NPAIR   = 8,
    parameter int              NBANK   = 2,
    parameter logic [2*DW-1:0] RST_VAL = '1
) (
    input  logic           clk,
    input  logic           reset,
    reg_bank_file_if.slave bus
);
    localparam int SELW  = $clog2(NPAIR);
    localparam int BW    = NBANK > 1 ? $clog2(NBANK) : 1;
    localparam int PW    = 2 * DW;
    localparam int NPHYS = 4 * NBANK + NPAIR - 4;

    logic [PW-1:0] regs_q [NPHYS];
    logic [PW-1:0] regs_d [NPHYS];
    logic [PW-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [BW-1:0] bank_af_q, bank_af_d, bank_gp_q, bank_gp_d;
    logic [NBANK-1:0] swap_q, swap_d;
    logic sw_cur;
    int wr_idx, ra_idx, rb_idx;

    // Physical layout: AF banks first, then three GP slots per bank, then the unbanked pairs; -1 = out of range
    function automatic int phys_idx(input logic [SELW-1:0] s, input logic [BW-1:0] baf, input logic [BW-1:0] bgp,
                                    input logic sw);
        int p;
        p = int'(s);
        if (p >= NPAIR) return -1;
        if (p == 0) return int'(baf);
        if (p < 4) return NBANK + 3 * int'(bgp) + ((sw && p != 1) ? 5 - p : p) - 1;
        return 4 * NBANK + p - 4;
    endfunction

    assign sw_cur        = swap_q[bank_gp_q];
    assign bus.rd_a_data = rd_a_q;
    assign bus.rd_b_data = rd_b_q;
    assign bus.bank_af   = bank_af_q;
    assign bus.bank_gp   = bank_gp_q;

`ifdef REG_BANK_FILE_INCDEC_EN
    int inc_idx;
`else
    logic unused_inc;
    assign unused_inc = ^{bus.inc_en, bus.inc_dec, bus.inc_sel};
`endif

    // Next pair contents (inc/dec, then byte-merged write on top) and write-first read data, all on pre-exchange mapping
    always_comb begin
        regs_d = regs_q;
        rd_a_d = '0;
        rd_b_d = '0;
        wr_idx = phys_idx(bus.wr_sel, bank_af_q, bank_gp_q, sw_cur);
        ra_idx = phys_idx(bus.rd_a_sel, bank_af_q, bank_gp_q, sw_cur);
        rb_idx = phys_idx(bus.rd_b_sel, bank_af_q, bank_gp_q, sw_cur);
`ifdef REG_BANK_FILE_INCDEC_EN
        inc_idx = phys_idx(bus.inc_sel, bank_af_q, bank_gp_q, sw_cur);
`endif
        for (int i = 0; i < NPHYS; i++) begin
`ifdef REG_BANK_FILE_INCDEC_EN
            if (bus.inc_en && inc_idx == i && !(bus.wr_we != 2'b00 && wr_idx == i))
                regs_d[i] = bus.inc_dec ? regs_q[i] - PW'(1) : regs_q[i] + PW'(1);
`endif
            if (wr_idx == i)
                regs_d[i] = {bus.wr_we[1] ? bus.wr_data[PW-1:DW] : regs_d[i][PW-1:DW],
                             bus.wr_we[0] ? bus.wr_data[DW-1:0]  : regs_d[i][DW-1:0]};
        end
        for (int i = 0; i < NPHYS; i++) begin
            if (i == ra_idx) rd_a_d = regs_d[i];
            if (i == rb_idx) rd_b_d = regs_d[i];
        end
    end

    // Bank pointers advance modulo NBANK; DE/HL swap flag of the pre-exchange GP bank toggles
    always_comb begin
        bank_af_d = bus.ex_af ? (bank_af_q == BW'(NBANK - 1) ? '0 : bank_af_q + 1'b1) : bank_af_q;
        bank_gp_d = bus.exx ? (bank_gp_q == BW'(NBANK - 1) ? '0 : bank_gp_q + 1'b1) : bank_gp_q;
        swap_d = swap_q;
        swap_d[bank_gp_q] = sw_cur ^ bus.ex_de_hl;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q    <= '{default: RST_VAL};
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            bank_af_q <= '0;
            bank_gp_q <= '0;
            swap_q    <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            bank_af_q <= bank_af_d;
            bank_gp_q <= bank_gp_d;
            swap_q    <= swap_d;
        end
    end
endmodule

// File: tb/tb_reg_bank_file.sv
// tb_reg_bank_file: directed scoreboard bench for reg_bank_file
module tb_reg_bank_file;
    localparam int K_A = 0, K_B = 1, K_AF = 2, K_GP = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc_cnt = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t e;
    logic [15:0] act;

    reg_bank_file_if #(.DW(8), .SELW(3), .BW(1)) bus ();

    reg_bank_file #(.DW(8), .NPAIR(8), .NBANK(2), .RST_VAL(16'hFFFF)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            act = e.kind == K_A ? bus.rd_a_data : e.kind == K_B ? bus.rd_b_data :
                  e.kind == K_AF ? 16'(bus.bank_af) : 16'(bus.bank_gp);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_at_next(input int kind, input logic [15:0] val, input string name);
        exp_t x;
        x.cyc  = cyc_cnt + 1;
        x.kind = kind;
        x.val  = val;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.wr_we    = 2'b00;
        bus.ex_af    = 1'b0;
        bus.exx      = 1'b0;
        bus.ex_de_hl = 1'b0;
        bus.inc_en   = 1'b0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [1:0] we, input logic [15:0] data);
        bus.wr_sel  = sel;
        bus.wr_we   = we;
        bus.wr_data = data;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        bus.rd_a_sel = a;
        bus.rd_b_sel = b;
    endtask

    initial begin
        bus.rd_a_sel = '0; bus.rd_b_sel = '0; bus.wr_sel = '0; bus.wr_we = '0; bus.wr_data = '0;
        bus.ex_af = 0; bus.exx = 0; bus.ex_de_hl = 0; bus.inc_en = 0; bus.inc_dec = 0; bus.inc_sel = '0;
        expect_at_next(K_A, 16'h0000, "rst_rd_a");
        expect_at_next(K_AF, 16'h0000, "rst_bank_af");
        expect_at_next(K_GP, 16'h0000, "rst_bank_gp");
        tick();
        tick();
        reset = 1'b0;
        rd(0, 0);
        expect_at_next(K_A, 16'hFFFF, "rst_val");
        tick();
        // write-first read and byte lanes
        wr(1, 2'b11, 16'hAB56); rd(1, 1);
        expect_at_next(K_A, 16'hAB56, "wr_first");
        tick();
        wr(1, 2'b01, 16'h1277);
        expect_at_next(K_A, 16'hAB77, "byte_lo");
        tick();
        wr(1, 2'b10, 16'hCD00);
        expect_at_next(K_B, 16'hCD77, "byte_hi");
        tick();
        wr(1, 2'b00, 16'h0000);
        expect_at_next(K_A, 16'hCD77, "we_00");
        tick();
        // exx on BC
        wr(1, 2'b11, 16'h1111);
        tick();
        bus.exx = 1'b1;
        expect_at_next(K_A, 16'h1111, "exx_pre_map");
        expect_at_next(K_GP, 16'h0001, "exx_bank1");
        tick();
        wr(1, 2'b11, 16'h2222);
        expect_at_next(K_A, 16'h2222, "bc_shadow");
        tick();
        bus.exx = 1'b1;
        expect_at_next(K_GP, 16'h0000, "exx_bank0");
        tick();
        expect_at_next(K_A, 16'h1111, "bc_back");
        tick();
        // ex_af with simultaneous write
        rd(0, 0);
        wr(0, 2'b11, 16'h5A5A); bus.ex_af = 1'b1;
        expect_at_next(K_A, 16'h5A5A, "af_wr_ex");
        expect_at_next(K_AF, 16'h0001, "ex_af_bank1");
        tick();
        expect_at_next(K_A, 16'hFFFF, "af_shadow");
        tick();
        wr(0, 2'b11, 16'h3C3C);
        tick();
        bus.ex_af = 1'b1;
        expect_at_next(K_B, 16'h3C3C, "af1_val");
        expect_at_next(K_AF, 16'h0000, "ex_af_bank0");
        tick();
        expect_at_next(K_A, 16'h5A5A, "af0_back");
        tick();
        // DE/HL swap
        wr(2, 2'b11, 16'hAC57);
        tick();
        wr(3, 2'b11, 16'hAD58);
        tick();
        rd(2, 3); bus.ex_de_hl = 1'b1;
        expect_at_next(K_A, 16'hAC57, "dehl_pre");
        tick();
        expect_at_next(K_A, 16'hAD58, "swap_de");
        expect_at_next(K_B, 16'hAC57, "swap_hl");
        tick();
        bus.exx = 1'b1;
        tick();
        wr(2, 2'b11, 16'h1357);
        expect_at_next(K_A, 16'h1357, "shadow_de");
        expect_at_next(K_B, 16'hFFFF, "shadow_hl_unswapped");
        tick();
        bus.exx = 1'b1;
        tick();
        expect_at_next(K_A, 16'hAD58, "swap_restored_de");
        expect_at_next(K_B, 16'hAC57, "swap_restored_hl");
        tick();
        // exx with ex_de_hl: old bank's swap toggles, then pointer advances
        bus.exx = 1'b1; bus.ex_de_hl = 1'b1;
        tick();
        expect_at_next(K_A, 16'h1357, "exx_dehl_bank1");
        tick();
        bus.exx = 1'b1;
        tick();
        expect_at_next(K_A, 16'hAC57, "exx_dehl_unswapped");
        expect_at_next(K_GP, 16'h0000, "exx_dehl_bank0");
        tick();
        // inc/dec
        wr(6, 2'b11, 16'hFFFF); rd(6, 7);
        tick();
        bus.inc_en = 1'b1; bus.inc_sel = 3'd6; bus.inc_dec = 1'b0;
`ifdef REG_BANK_FILE_INCDEC_EN
        expect_at_next(K_A, 16'h0000, "inc_wrap");
        tick();
        bus.inc_en = 1'b1; bus.inc_dec = 1'b1;
        expect_at_next(K_A, 16'hFFFF, "dec_wrap");
        tick();
        bus.inc_en = 1'b1; bus.inc_dec = 1'b0; wr(6, 2'b11, 16'h1234);
        expect_at_next(K_A, 16'h1234, "inc_vs_wr");
        tick();
        bus.inc_en = 1'b1; wr(7, 2'b01, 16'h00AA);
        expect_at_next(K_A, 16'h1235, "inc_other_wr");
        expect_at_next(K_B, 16'hFFAA, "wr_other_inc");
        tick();
`else
        expect_at_next(K_A, 16'hFFFF, "inc_disabled");
        tick();
        bus.inc_en = 1'b1; bus.inc_dec = 1'b1;
        expect_at_next(K_A, 16'hFFFF, "dec_disabled");
        tick();
`endif
        // reset mid-operation discards pending exchange and clears state
        bus.ex_af = 1'b1;
        tick();
        rd(1, 1);
        bus.ex_af = 1'b1; bus.exx = 1'b1;
        #2 reset = 1'b1;
        expect_at_next(K_A, 16'h0000, "midrst_rd");
        expect_at_next(K_AF, 16'h0000, "midrst_bank_af");
        expect_at_next(K_GP, 16'h0000, "midrst_bank_gp");
        tick();
        reset = 1'b0;
        expect_at_next(K_A, 16'hFFFF, "midrst_pair1");
        tick();
        repeat (3) tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
